// File: rtl/counter_pkg.sv
// Shared definitions for the multi-channel counter bank.
package counter_pkg;

  localparam int unsigned MAX_NUM_CH = 16;

  // All-ones value for a counter of the given width (width 1..32).
  function automatic logic [31:0] count_max(input int unsigned width);
    logic [31:0] m;
    if (width >= 32) m = '1;
    else             m = (32'd1 << width) - 32'd1;
    return m;
  endfunction

  // Per-channel control strobes bundled for the channel instance.
  typedef struct packed {
    logic en;
    logic up;
    logic sat;
    logic load;
    logic ovf_clr;
  } ch_ctrl_t;

endpackage

// File: rtl/counter_channel.sv
// One up/down counter channel: load, wrap/saturate, terminal-count pulse
// and sticky overflow flag.
module counter_channel
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  ch_ctrl_t         ctrl,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(count_max(WIDTH));

  logic             at_limit;
  logic             tc_event;
  logic [WIDTH-1:0] q_next;

  // Next count value and terminal-count detection for the sampled controls.
  always_comb begin
    at_limit = ctrl.up ? (q == MAX) : (q == '0);
    tc_event = ctrl.en & ~ctrl.load & at_limit;
    q_next   = q;
    if (ctrl.load) begin
      q_next = load_val;
    end else if (ctrl.en) begin
      if (at_limit && ctrl.sat) q_next = q;
      else if (ctrl.up)         q_next = q + WIDTH'(1);
      else                      q_next = q - WIDTH'(1);
    end
  end

  // Count, pulse and sticky-flag registers; a set of ovf beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      tc  <= tc_event;
      ovf <= tc_event | (ovf & ~ctrl.ovf_clr);
    end
  end

endmodule

// File: rtl/multi_counter.sv
// N-channel up/down counter bank; slices the flat buses onto channels.
module multi_counter
  import counter_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       up,
  input  logic [NUM_CH-1:0]       sat,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH-1:0]       ovf_clr,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       ovf
);

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    ch_ctrl_t ctrl;

    // Bundle this channel's control strobes.
    always_comb begin
      ctrl = '{en: en[i], up: up[i], sat: sat[i], load: load[i], ovf_clr: ovf_clr[i]};
    end

    counter_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .ctrl     (ctrl),
      .load_val (load_val[i*WIDTH +: WIDTH]),
      .q        (q[i*WIDTH +: WIDTH]),
      .tc       (tc[i]),
      .ovf      (ovf[i])
    );
  end

endmodule

// File: tb/tb_multi_counter.sv
// Directed self-checking bench for multi_counter (4x4 build plus a 1x32 build).
module tb_multi_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  en, up, sat, load, ovf_clr;
  logic [15:0] load_val;
  logic [15:0] q;
  logic [3:0]  tc, ovf;

  logic [0:0]  en2, up2, sat2, load2, ovf_clr2;
  logic [31:0] load_val2;
  logic [31:0] q2;
  logic [0:0]  tc2, ovf2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  multi_counter #(.NUM_CH(4), .WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .q(q), .tc(tc), .ovf(ovf)
  );

  multi_counter #(.NUM_CH(1), .WIDTH(32)) dut_wide (
    .clk(clk), .reset(reset), .en(en2), .up(up2), .sat(sat2), .load(load2),
    .load_val(load_val2), .ovf_clr(ovf_clr2), .q(q2), .tc(tc2), .ovf(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 4'hF; load = 4'hF; load_val = 16'hFFFF; up = 4'hF; sat = 4'h0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (q !== 16'h0000) begin n_bad++; $display("FAIL reset_q got %h want %h", q, 16'h0000); end
      n_cmp++; if (tc !== 4'h0) begin n_bad++; $display("FAIL reset_tc got %h want %h", tc, 4'h0); end
      n_cmp++; if (ovf !== 4'h0) begin n_bad++; $display("FAIL reset_ovf got %h want %h", ovf, 4'h0); end
    end
    reset = 1'b0; en = 4'h1; load = 4'h0; load_val = 16'h0000; up = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++; if (q !== 16'(c)) begin n_bad++; $display("FAIL release_count got %h want %h", q, 16'(c)); end
    end
  endtask

  task automatic test_wrap_up();
    en = 4'h0; load = 4'h1; load_val = 16'h000E;
    tick();
    n_cmp++; if (q[3:0] !== 4'hE) begin n_bad++; $display("FAIL wrap_load got %h want %h", q[3:0], 4'hE); end
    load = 4'h0; en = 4'h1; up = 4'h1; sat = 4'h0;
    tick();
    n_cmp++; if ({q[3:0], tc[0], ovf[0]} !== {4'hF, 1'b0, 1'b0}) begin n_bad++; $display("FAIL wrap_F got q=%h tc=%b ovf=%b want q=f tc=0 ovf=0", q[3:0], tc[0], ovf[0]); end
    tick();
    n_cmp++; if ({q[3:0], tc[0], ovf[0]} !== {4'h0, 1'b1, 1'b1}) begin n_bad++; $display("FAIL wrap_0 got q=%h tc=%b ovf=%b want q=0 tc=1 ovf=1", q[3:0], tc[0], ovf[0]); end
    tick();
    n_cmp++; if ({q[3:0], tc[0], ovf[0]} !== {4'h1, 1'b0, 1'b1}) begin n_bad++; $display("FAIL wrap_1 got q=%h tc=%b ovf=%b want q=1 tc=0 ovf=1", q[3:0], tc[0], ovf[0]); end
    en = 4'h0; ovf_clr = 4'h1;
    tick();
    n_cmp++; if ({q[3:0], tc[0], ovf[0]} !== {4'h1, 1'b0, 1'b0}) begin n_bad++; $display("FAIL ovf_clear got q=%h tc=%b ovf=%b want q=1 tc=0 ovf=0", q[3:0], tc[0], ovf[0]); end
    ovf_clr = 4'h0;
  endtask

  task automatic test_sat_down();
    en = 4'h0; load = 4'h2; load_val = 16'h0010;
    tick();
    n_cmp++; if (q[7:4] !== 4'h1) begin n_bad++; $display("FAIL sat_load got %h want %h", q[7:4], 4'h1); end
    load = 4'h0; en = 4'h2; up = 4'h0; sat = 4'h2;
    tick();
    n_cmp++; if ({q[7:4], tc[1], ovf[1]} !== {4'h0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL sat_step got q=%h tc=%b ovf=%b want q=0 tc=0 ovf=0", q[7:4], tc[1], ovf[1]); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if ({q[7:4], tc[1], ovf[1]} !== {4'h0, 1'b1, 1'b1}) begin n_bad++; $display("FAIL sat_hold got q=%h tc=%b ovf=%b want q=0 tc=1 ovf=1", q[7:4], tc[1], ovf[1]); end
    end
    en = 4'h0; sat = 4'h0;
    tick();
    n_cmp++; if ({q[7:4], tc[1], ovf[1]} !== {4'h0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL idle_hold got q=%h tc=%b ovf=%b want q=0 tc=0 ovf=1", q[7:4], tc[1], ovf[1]); end
  endtask

  task automatic test_priority();
    en = 4'h0; load = 4'h4; load_val = 16'h0700;
    tick();
    n_cmp++; if (q[11:8] !== 4'h7) begin n_bad++; $display("FAIL prio_setup got %h want %h", q[11:8], 4'h7); end
    load = 4'h4; load_val = 16'h0300; en = 4'h4; up = 4'h4;
    tick();
    n_cmp++; if ({q[11:8], tc[2]} !== {4'h3, 1'b0}) begin n_bad++; $display("FAIL prio_load got q=%h tc=%b want q=3 tc=0", q[11:8], tc[2]); end
    load = 4'h0; en = 4'h0;
  endtask

  task automatic test_collision();
    load = 4'h8; load_val = 16'hF000;
    tick();
    n_cmp++; if (q[15:12] !== 4'hF) begin n_bad++; $display("FAIL coll_setup got %h want %h", q[15:12], 4'hF); end
    load = 4'h0; en = 4'h8; up = 4'h8; sat = 4'h0; ovf_clr = 4'h8;
    tick();
    n_cmp++; if ({q[15:12], tc[3], ovf[3]} !== {4'h0, 1'b1, 1'b1}) begin n_bad++; $display("FAIL collision got q=%h tc=%b ovf=%b want q=0 tc=1 ovf=1", q[15:12], tc[3], ovf[3]); end
    en = 4'h0; ovf_clr = 4'h0;
  endtask

  task automatic test_mid_reset();
    load = 4'hF; load_val = 16'h5555; en = 4'hF;
    tick();
    n_cmp++; if ({q, ovf[3]} !== {16'h5555, 1'b1}) begin n_bad++; $display("FAIL load_all got q=%h ovf3=%b want q=5555 ovf3=1", q, ovf[3]); end
    load = 4'h0; up = 4'hF; sat = 4'h0;
    tick();
    tick();
    n_cmp++; if (q !== 16'h7777) begin n_bad++; $display("FAIL count_all got %h want %h", q, 16'h7777); end
    reset = 1'b1;
    tick();
    n_cmp++; if ({q, tc, ovf} !== 24'h0) begin n_bad++; $display("FAIL mid_reset got q=%h tc=%h ovf=%h want all 0", q, tc, ovf); end
    reset = 1'b0; en = 4'h0;
  endtask

  task automatic test_wide();
    load2 = 1'b1; load_val2 = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (q2 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wide_load got %h want %h", q2, 32'hFFFF_FFFF); end
    load2 = 1'b0; en2 = 1'b1; up2 = 1'b1; sat2 = 1'b0;
    tick();
    n_cmp++; if ({q2, tc2, ovf2} !== {32'h0, 1'b1, 1'b1}) begin n_bad++; $display("FAIL wide_wrap got q=%h tc=%b ovf=%b want q=0 tc=1 ovf=1", q2, tc2, ovf2); end
    en2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = '0; up = '0; sat = '0; load = '0; load_val = '0; ovf_clr = '0;
    en2 = '0; up2 = '0; sat2 = '0; load2 = '0; load_val2 = '0; ovf_clr2 = '0;
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_priority();
    test_collision();
    test_mid_reset();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_counter.md
Name: multi_counter

Overview:
- Parametrised N-channel up/down counter bank; successor to the fixed two-output enable-only counter.
- Adds the following, all per channel:
  - synchronous load
  - count direction
  - wrap or saturate mode
  - terminal-count pulse
  - sticky overflow flag
- Sits under a top-level wrapper.
- Outputs feed monitors, timers and event logic.

Parameters:
- NUM_CH, 4, number of independent counter channels (1..16).
- WIDTH, 8, counter width in bits (2..32).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  NUM_CH  per-channel count enable.
- up  input  NUM_CH  per-channel direction; 1 = increment, 0 = decrement.
- sat  input  NUM_CH  per-channel mode; 1 = saturate at the limits, 0 = wrap.
- load  input  NUM_CH  per-channel synchronous load strobe.
- load_val  input  NUM_CH*WIDTH  load values; channel i occupies bits [i*WIDTH +: WIDTH].
- ovf_clr  input  NUM_CH  per-channel clear of the sticky overflow flag.
- q  output  NUM_CH*WIDTH  count values, same packing as load_val.
- tc  output  NUM_CH  one-cycle terminal-count pulse.
- ovf  output  NUM_CH  sticky overflow flag.

Behaviour:
- Scope: all state is updated on the rising edge of clk; every channel is independent.
- Reset: when reset=1 at an edge, every q = 0, tc = 0, ovf = 0. Reset overrides all other inputs and takes effect mid-count.
- Priority per channel: reset > load > en.
- Load: load=1 sets q to load_val on the next edge, regardless of en, up or sat. tc = 0 that cycle; ovf is unchanged.
- Count, up=1:
  - q < MAX (2^WIDTH-1): q+1.
  - q == MAX: wraps to 0 if sat=0; stays at MAX if sat=1.
- Count, up=0:
  - q > 0: q-1.
  - q == 0: wraps to MAX if sat=0; stays at 0 if sat=1.
- Terminal-count event: en=1, load=0, and q is at the limit in the current count direction (MAX going up, 0 going down), in either mode.
- tc:
  - Registered; high for exactly the one cycle after the edge at which the event is sampled, i.e. aligned with the wrapped or held value on q.
  - With sat=1 and en held at the limit, tc stays high every cycle. This is intended; it indicates a continuous hit.
- ovf:
  - Set on an edge where a terminal-count event occurs.
  - Cleared on an edge where ovf_clr=1.
  - If set and clear coincide, set wins.
- en=0 and load=0: q, ovf hold; tc = 0.
- Arithmetic: modulo 2^WIDTH, no carry out beyond ovf. up, sat and en may change on any cycle; the value sampled at the edge is used.
- Latency: one cycle from input to q/tc/ovf. No combinational input-to-output paths.

Decomposition:
- Package counter_pkg holds:
  - localparam MAX_NUM_CH = 16.
  - function count_max(width).
  - typedef ch_ctrl_t, a packed struct {en, up, sat, load, ovf_clr}, used internally to bundle per-channel controls.
- Sub-module counter_channel (parameter WIDTH):
  - One channel: q, tc and ovf registers plus next-state logic.
  - Instantiated NUM_CH times by a generate loop in multi_counter, which only slices the flat buses.

Test Plan (WIDTH=4, NUM_CH=4 unless stated):
- Reset: hold reset=1 two cycles with en=4'hF, load=4'hF, load_val=16'hFFFF -> q=0, tc=0, ovf=0 throughout. Release with en=4'h1, up=1 -> ch0 q reads 1,2,3 on successive cycles; other channels stay 0.
- Wrap up: ch0 load 4'hE, then en=1, up=1, sat=0 -> q reads F, 0, 1. tc=1 only in the cycle q=0. ovf goes 1 then stays 1. ovf_clr pulse -> ovf=0 next cycle.
- Saturate down: ch1 load 4'h1, en=1, up=0, sat=1 -> q reads 0, 0, 0. tc=1 in every cycle q is held at 0; ovf=1.
- Priority: ch2 at q=4'h7 with load=1, load_val=4'h3, en=1, up=1 -> q=3 next cycle, not 8; tc=0.
- Set/clear collision: ch3 at q=F, up=1, sat=0, en=1, ovf_clr=1 on the same edge -> q=0, tc=1, ovf=1.
- Mid-count reset: all channels counting; assert reset one cycle -> all q=0, ovf=0 next cycle. NUM_CH=1, WIDTH=32 build: load 32'hFFFF_FFFF, up=1 -> q=0, tc=1.
